// File: rtl/revo_clock_encoded_trigger_decoder.sv
// Decodes revo triggers from the IDDR sample pair of a clock-encoded trg line, learns the
// revo period and flywheels over missing revos with synthetic pulses.
module revo_clock_encoded_trigger_decoder #(
    parameter int COUNTER_WIDTH = 16,
    parameter int LOCK_COUNT    = 4,
    parameter int MAX_MISSES    = 3,
    parameter int ERROR_WIDTH   = 8,
    localparam int MISS_W       = $clog2(MAX_MISSES + 1),
    localparam int MATCH_W      = $clog2(LOCK_COUNT + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enc_rise,
    input  logic                     enc_fall,
    output logic                     trigger_out,
    output logic                     revo_out,
    output logic                     revo_synthetic,
    output logic                     unexpected_trigger,
    output logic                     coding_error,
    output logic                     locked,
    output logic [1:0]               state,
    output logic [COUNTER_WIDTH-1:0] period,
    output logic [MISS_W-1:0]        miss_count,
    output logic [ERROR_WIDTH-1:0]   error_count
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    function automatic logic [COUNTER_WIDTH-1:0] counter_inc(input logic [COUNTER_WIDTH-1:0] v);
        return (&v) ? v : v + COUNTER_WIDTH'(1);
    endfunction

    function automatic logic [ERROR_WIDTH-1:0] error_inc(input logic [ERROR_WIDTH-1:0] v);
        return (&v) ? v : v + ERROR_WIDTH'(1);
    endfunction

    state_t                   state_q;
    state_t                   state_next;
    logic [1:0]               sym_p0;
    logic                     vld_p0;
    logic                     prev_trig_p1;
    logic [COUNTER_WIDTH-1:0] counter_q;
    logic [COUNTER_WIDTH-1:0] counter_next;
    logic [COUNTER_WIDTH-1:0] period_next;
    logic [MATCH_W-1:0]       match_q;
    logic [MATCH_W-1:0]       match_next;
    logic [MATCH_W-1:0]       match_inc;
    logic [MISS_W-1:0]        miss_next;
    logic                     sym_trig;
    logic                     sym_err;
    logic                     trig;
    logic                     at_period;
    logic                     revo_d;
    logic                     synth_d;
    logic                     unexp_d;

    // Stage p0: capture the raw IDDR symbol.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sym_p0 <= 2'b01;
            vld_p0 <= 1'b0;
        end else begin
            sym_p0 <= {enc_rise, enc_fall};
            vld_p0 <= 1'b1;
        end
    end

    // Stage p1: classify the symbol; {0,0} and {1,0} are both missing the high second half.
    assign sym_trig  = vld_p0 && (sym_p0 == 2'b11);
    assign sym_err   = vld_p0 && !sym_p0[0];
    assign trig      = sym_trig && !prev_trig_p1;
    assign at_period = (counter_q == period);
    assign state     = state_q;
    assign locked    = (state_q == LOCKED);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= UNLOCKED;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next   = state_q;
        counter_next = counter_inc(counter_q);
        period_next  = period;
        match_next   = match_q;
        match_inc    = '0;
        miss_next    = miss_count;
        case (state_q)
            UNLOCKED: begin
                if (trig) begin
                    counter_next = COUNTER_WIDTH'(1);
                    match_next   = '0;
                    state_next   = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (trig) begin
                    counter_next = COUNTER_WIDTH'(1);
                    if ((match_q != '0) && at_period) begin
                        match_inc = match_q + MATCH_W'(1);
                    end else begin
                        period_next = counter_q;
                        match_inc   = MATCH_W'(1);
                    end
                    match_next = match_inc;
                    if (match_inc == MATCH_W'(LOCK_COUNT)) begin
                        state_next = LOCKED;
                        miss_next  = '0;
                    end
                end else if (&counter_q) begin
                    state_next = UNLOCKED;
                end
            end
            LOCKED: begin
                // Off-phase triggers leave the counter running so the flywheel keeps its phase.
                if (at_period) begin
                    counter_next = COUNTER_WIDTH'(1);
                    if (trig) begin
                        miss_next = '0;
                    end else begin
                        miss_next = miss_count + MISS_W'(1);
                        if (miss_next == MISS_W'(MAX_MISSES)) begin
                            state_next = UNLOCKED;
                        end
                    end
                end
            end
            default: begin
                state_next = UNLOCKED;
            end
        endcase
    end

    always_comb begin
        revo_d  = 1'b0;
        synth_d = 1'b0;
        unexp_d = 1'b0;
        case (state_q)
            UNLOCKED, ACQUIRE: begin
                revo_d = trig;
            end
            LOCKED: begin
                if (at_period) begin
                    revo_d  = 1'b1;
                    synth_d = !trig;
                end else begin
                    unexp_d = trig;
                end
            end
            default: begin
                revo_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_trig_p1       <= 1'b0;
            counter_q          <= '0;
            period             <= '0;
            match_q            <= '0;
            miss_count         <= '0;
            error_count        <= '0;
            trigger_out        <= 1'b0;
            revo_out           <= 1'b0;
            revo_synthetic     <= 1'b0;
            unexpected_trigger <= 1'b0;
            coding_error       <= 1'b0;
        end else begin
            prev_trig_p1       <= sym_trig;
            counter_q          <= counter_next;
            period             <= period_next;
            match_q            <= match_next;
            miss_count         <= miss_next;
            error_count        <= sym_err ? error_inc(error_count) : error_count;
            trigger_out        <= trig;
            revo_out           <= revo_d;
            revo_synthetic     <= synth_d;
            unexpected_trigger <= unexp_d;
            coding_error       <= sym_err;
        end
    end

endmodule
